rr_mux_arbiter: RTL and testbench

- Round-robin arbiter that sequences a shared N:1 mux: multiple requesters compete for one output channel.
- Each requester presents a data word plus a req. The arbiter selects one requester and captures its word into an output register. It presents the word on a valid/ready channel and holds it until the word is accepted.
- Sits between independent producers and a single downstream consumer. It is the scheduler for the 2:1 mux datapath, generalised to NUM_REQ inputs.

---
 rtl/rr_mux_arbiter.sv | 85 ++++++++
 tb/tb_rr_mux_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter feeding an N:1 mux into a registered valid/ready output stage.
// The grant is combinational; the winning word is captured on the grant edge.
module rr_mux_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SEL_W   = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   data_in,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [SEL_W-1:0]            out_sel,
  input  logic                        out_ready
);

  localparam int unsigned SW1 = SEL_W + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [SEL_W-1:0]   ptr, ptr_next, gnt_idx;
  logic [NUM_REQ-1:0] req_rot;
  logic [SW1-1:0]     idx_sum;
  logic               found, cap_ok, grant_ok;

  assign out_valid = (state == FULL);
  assign cap_ok    = (state == EMPTY) || out_ready;

  // Rotate so bit 0 is the requester at ptr; the first set bit wins.
  assign req_rot = NUM_REQ'({req, req} >> ptr);

  always_comb begin
    found   = 1'b0;
    idx_sum = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found   = 1'b1;
        idx_sum = {1'b0, ptr} + SW1'(i);
      end
    end
    // Explicit modulo so non-power-of-2 NUM_REQ wraps correctly.
    if (idx_sum >= SW1'(NUM_REQ)) begin
      idx_sum = idx_sum - SW1'(NUM_REQ);
    end
    gnt_idx  = idx_sum[SEL_W-1:0];
    grant_ok = found && cap_ok && !rst;
    gnt      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      gnt[k] = grant_ok && (gnt_idx == SEL_W'(k));
    end
  end

  always_comb begin
    ptr_next   = (gnt_idx == SEL_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    state_next = state;
    if (grant_ok) begin
      state_next = FULL;
    end else if ((state == FULL) && out_ready) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
    end else begin
      state <= state_next;
      if (grant_ok) begin
        out_data <= data_in[gnt_idx*DATA_W +: DATA_W];
        out_sel  <= gnt_idx;
        ptr      <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: behavioural round-robin model plus a scoreboard of captured words,
// with directed scenarios followed by random traffic.
module tb_rr_mux_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   gnt;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] d;
    logic [1:0]   s;
  } item_t;
  item_t sb[$];

  int m_ptr  = 0;
  bit m_full = 1'b0;

  rr_mux_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .gnt(gnt),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_gnt();
    if (rst) return '0;
    if (m_full && !out_ready) return '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (req[k]) return N'(1) << k;
    end
    return '0;
  endfunction

  function automatic logic [W-1:0] slice(input int k);
    logic [N*W-1:0] v;
    v = data_in;
    return v[k*W +: W];
  endfunction

  // Called #1 after a rising edge with inputs already driven; returns #1 after the next edge.
  task automatic cycle_expect(input logic [N-1:0] want, input bit use_want);
    logic [N-1:0] eg;
    item_t it;
    int k;
    @(negedge clk);
    eg = model_gnt();
    checks++;
    if (gnt !== eg) begin
      errors++;
      $display("FAIL gnt_model: got %b expected %b", gnt, eg);
    end
    if (use_want) begin
      checks++;
      if (gnt !== want) begin
        errors++;
        $display("FAIL gnt_directed: got %b expected %b", gnt, want);
      end
    end
    checks++;
    if (out_valid !== m_full) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b", out_valid, m_full);
    end
    if (m_full && !rst) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got valid word %h expected none", out_data);
      end else begin
        it = sb[0];
        checks++;
        if (out_data !== it.d || out_sel !== it.s) begin
          errors++;
          $display("FAIL out_word: got data=%h sel=%0d expected data=%h sel=%0d",
                   out_data, out_sel, it.d, it.s);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
    k = -1;
    for (int i = 0; i < N; i++) if (eg[i]) k = i;
    if (k >= 0) begin
      it.d = slice(k);
      it.s = 2'(k);
      sb.push_back(it);
    end
    @(posedge clk);
    if (rst) begin
      m_full = 1'b0;
      m_ptr  = 0;
      sb.delete();
    end else if (k >= 0) begin
      m_full = 1'b1;
      m_ptr  = (k + 1) % N;
    end else if (m_full && out_ready) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic cycle();
    cycle_expect('0, 1'b0);
  endtask

  task automatic set_slices(input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input logic [W-1:0] d3);
    data_in = {d3, d2, d1, d0};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    out_ready = 1'b1;
    set_slices(8'h10, 8'h11, 8'h12, 8'h13);
    cycle_expect(4'b0000, 1'b1);
    cycle_expect(4'b0000, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h s=%0d expected v=0 d=00 s=0",
               out_valid, out_data, out_sel);
    end
    rst = 1'b0;
    cycle_expect(4'b0001, 1'b1);
    req = '0;
    cycle();
  endtask

  task automatic test_single();
    req = 4'b0100;
    set_slices(8'h00, 8'h00, 8'hA5, 8'h00);
    out_ready = 1'b1;
    cycle_expect(4'b0100, 1'b1);
    req = '0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 2'd2) begin
      errors++;
      $display("FAIL single_capture: got v=%b d=%h s=%0d expected v=1 d=a5 s=2",
               out_valid, out_data, out_sel);
    end
    cycle();
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_seq[5];
    logic [N-1:0] exp_gnt[5];
    exp_seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1;
    req = '0;
    cycle();
    rst = 1'b0;
    req = 4'b1111;
    out_ready = 1'b1;
    set_slices(8'h10, 8'h11, 8'h12, 8'h13);
    for (int i = 0; i < 5; i++) begin
      cycle_expect(exp_gnt[i], 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got v=%b d=%h expected v=1 d=%h",
                 i, out_valid, out_data, exp_seq[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    cycle_expect(4'b0010, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle_expect(4'b0000, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || out_sel !== 2'd1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d expected v=1 d=11 s=1",
                 i, out_valid, out_data, out_sel);
      end
    end
    out_ready = 1'b1;
    cycle_expect(4'b0100, 1'b1);
    checks++;
    if (out_data !== 8'h12 || out_sel !== 2'd2) begin
      errors++;
      $display("FAIL bp_release: got d=%h s=%0d expected d=12 s=2", out_data, out_sel);
    end
    req = '0;
    cycle();
  endtask

  task automatic test_wrap_skip();
    req = 4'b0011;
    out_ready = 1'b1;
    cycle_expect(4'b0001, 1'b1);
    cycle_expect(4'b0010, 1'b1);
    checks++;
    if (out_sel !== 2'd1 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL wrap_skip: got d=%h s=%0d expected d=11 s=1", out_data, out_sel);
    end
    req = '0;
    cycle();
  endtask

  task automatic test_reset_mid();
    req = 4'b0010;
    out_ready = 1'b1;
    cycle_expect(4'b0010, 1'b1);
    req = '0;
    out_ready = 1'b0;
    rst = 1'b1;
    cycle_expect(4'b0000, 1'b1);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_valid: got %b expected 0", out_valid);
    end
    req = 4'b0101;
    out_ready = 1'b1;
    cycle_expect(4'b0001, 1'b1);
    req = 4'b1000;
    cycle_expect(4'b1000, 1'b1);
    checks++;
    if (out_sel !== 2'd3 || out_data !== 8'h13) begin
      errors++;
      $display("FAIL reset_mid_sel: got d=%h s=%0d expected d=13 s=3", out_data, out_sel);
    end
    req = '0;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req       = N'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      data_in   = $urandom();
      cycle();
    end
    req = '0;
    out_ready = 1'b1;
    cycle();
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    data_in = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
